imem_boot_ctrl: RTL and testbench

//  Sequences the instruction memory between program load and execution: it streams

---
 rtl/imem_boot_ctrl.sv | 124 ++++++++++++
 tb/tb_imem_boot_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot sequencer: streams host words into imem,
// then releases the CPU with a one-cycle PC reset.
module imem_boot_ctrl #(
    parameter int          ADDR_W   = 16,
    parameter logic [31:0] NOP_WORD = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic [31:0] load_base,
    input  logic [16:0] load_len,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        halt,
    input  logic [31:0] fetch_addr,
    output logic [31:0] fetch_instr,
    output logic        cpu_run,
    output logic        pc_reset,
    output logic        load_done,
    output logic        busy,
    output logic        err_ovf,
    output logic [31:0] mem_read_addr,
    output logic [31:0] mem_write_addr,
    output logic        mem_write_en,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] base;
    logic [16:0]       len;
    logic [16:0]       idx;

    logic beat;
    logic last;
    logic start_ok;
    logic start_bad;

    assign beat      = (state == LOAD) && ld_valid;
    assign last      = (idx == len - 17'd1);
    assign start_ok  = load_start && ((state == IDLE) || (state == RUN));
    assign start_bad = load_start && ((state == LOAD) || (state == FLUSH));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (load_start)
                    state_nx = (load_len == 17'd0) ? FLUSH : LOAD;
            end
            LOAD: begin
                if (beat && last)
                    state_nx = FLUSH;
            end
            FLUSH: begin
                state_nx = RUN;
            end
            RUN: begin
                // A reload request takes priority over halt.
                if (load_start)
                    state_nx = (load_len == 17'd0) ? FLUSH : LOAD;
                else if (halt)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            base    <= '0;
            len     <= '0;
            idx     <= '0;
            err_ovf <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                base    <= load_base[ADDR_W-1:0];
                len     <= load_len;
                idx     <= '0;
                err_ovf <= 1'b0;
            end else begin
                if (beat)
                    idx <= idx + 17'd1;
                if (start_bad)
                    err_ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        mem_write_addr = '0;
        mem_write_en   = 1'b0;
        mem_data_in    = '0;
        if (beat) begin
            mem_write_en                = 1'b1;
            mem_write_addr[ADDR_W-1:0]  = base + idx[ADDR_W-1:0];
            mem_data_in                 = ld_data;
        end
    end

    always_comb begin
        mem_read_addr             = '0;
        mem_read_addr[ADDR_W-1:0] = fetch_addr[ADDR_W-1:0];
    end

    assign ld_ready    = (state == LOAD);
    assign busy        = (state == LOAD) || (state == FLUSH);
    assign pc_reset    = (state == FLUSH);
    assign load_done   = (state == FLUSH);
    assign cpu_run     = (state == RUN);
    assign fetch_instr = (state == RUN) ? mem_data_out : NOP_WORD;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with a behavioural imem and
// a log of every write the controller issues.
module tb_imem_boot_ctrl;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic [31:0] load_base;
    logic [16:0] load_len;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        halt;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_instr;
    logic        cpu_run;
    logic        pc_reset;
    logic        load_done;
    logic        busy;
    logic        err_ovf;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_write_addr;
    logic        mem_write_en;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    int vecs  = 0;
    int fails = 0;

    logic [31:0] tmem [0:65535];
    logic [31:0] wa [$];
    logic [31:0] wd [$];

    imem_boot_ctrl #(.ADDR_W(16), .NOP_WORD(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .load_base     (load_base),
        .load_len      (load_len),
        .ld_valid      (ld_valid),
        .ld_data       (ld_data),
        .ld_ready      (ld_ready),
        .halt          (halt),
        .fetch_addr    (fetch_addr),
        .fetch_instr   (fetch_instr),
        .cpu_run       (cpu_run),
        .pc_reset      (pc_reset),
        .load_done     (load_done),
        .busy          (busy),
        .err_ovf       (err_ovf),
        .mem_read_addr (mem_read_addr),
        .mem_write_addr(mem_write_addr),
        .mem_write_en  (mem_write_en),
        .mem_data_in   (mem_data_in),
        .mem_data_out  (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data_out = tmem[mem_read_addr[15:0]];

    always @(posedge clk) begin
        if (mem_write_en) begin
            tmem[mem_write_addr[15:0]] <= mem_data_in;
            wa.push_back(mem_write_addr);
            wd.push_back(mem_data_in);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] b, input logic [16:0] l);
        @(negedge clk);
        load_start = 1'b1;
        load_base  = b;
        load_len   = l;
        @(negedge clk);
        load_start = 1'b0;
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic [31:0] ea, input string nm);
        ld_valid = 1'b1;
        ld_data  = d;
        #1;
        vecs++;
        if (mem_write_en !== 1'b1 || mem_write_addr !== ea || mem_data_in !== d) begin
            fails++;
            $display("FAIL %s: we=%b addr=%h data=%h, want we=1 addr=%h data=%h",
                     nm, mem_write_en, mem_write_addr, mem_data_in, ea, d);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        vecs++;
        if ({ld_ready, cpu_run, pc_reset, load_done, busy, err_ovf, mem_write_en} !== 7'b0
            || fetch_instr !== 32'h0) begin
            fails++;
            $display("FAIL reset_outs: rdy=%b run=%b pcr=%b done=%b busy=%b ovf=%b we=%b instr=%h, want all 0",
                     ld_ready, cpu_run, pc_reset, load_done, busy, err_ovf, mem_write_en, fetch_instr);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_load_basic();
        int n0;
        n0 = wa.size();
        start(32'h10, 17'd3);
        vecs++;
        if (ld_ready !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL load_enter: rdy=%b busy=%b, want 1 1", ld_ready, busy);
        end
        beat(32'hAAAA_0001, 32'h10, "beat_a");
        vecs++;
        if (mem_write_en !== 1'b0 || ld_ready !== 1'b1) begin
            fails++;
            $display("FAIL gap: we=%b rdy=%b, want 0 1", mem_write_en, ld_ready);
        end
        @(negedge clk);
        beat(32'hBBBB_0002, 32'h11, "beat_b");
        beat(32'hCCCC_0003, 32'h12, "beat_c");
        vecs++;
        if (pc_reset !== 1'b1 || load_done !== 1'b1 || ld_ready !== 1'b0
            || busy !== 1'b1 || cpu_run !== 1'b0) begin
            fails++;
            $display("FAIL flush: pcr=%b done=%b rdy=%b busy=%b run=%b, want 1 1 0 1 0",
                     pc_reset, load_done, ld_ready, busy, cpu_run);
        end
        fetch_addr = 32'h11;
        step();
        vecs++;
        if (cpu_run !== 1'b1 || pc_reset !== 1'b0 || fetch_instr !== 32'hBBBB_0002) begin
            fails++;
            $display("FAIL run_fetch: run=%b pcr=%b instr=%h, want 1 0 bbbb0002",
                     cpu_run, pc_reset, fetch_instr);
        end
        vecs++;
        if (wa.size() - n0 != 3 || tmem[16'h10] !== 32'hAAAA_0001
            || tmem[16'h12] !== 32'hCCCC_0003) begin
            fails++;
            $display("FAIL load_mem: writes=%0d m10=%h m12=%h, want 3 aaaa0001 cccc0003",
                     wa.size() - n0, tmem[16'h10], tmem[16'h12]);
        end
        fetch_addr = 32'h0001_0012;
        #1;
        vecs++;
        if (mem_read_addr !== 32'h12 || fetch_instr !== 32'hCCCC_0003) begin
            fails++;
            $display("FAIL read_addr: raddr=%h instr=%h, want 00000012 cccc0003",
                     mem_read_addr, fetch_instr);
        end
    endtask

    task automatic test_halt();
        int n0;
        n0 = wa.size();
        @(negedge clk);
        halt       = 1'b1;
        load_start = 1'b1;
        load_base  = 32'h20;
        load_len   = 17'd1;
        @(negedge clk);
        halt       = 1'b0;
        load_start = 1'b0;
        #1;
        vecs++;
        if (busy !== 1'b1 || ld_ready !== 1'b1 || cpu_run !== 1'b0) begin
            fails++;
            $display("FAIL start_beats_halt: busy=%b rdy=%b run=%b, want 1 1 0",
                     busy, ld_ready, cpu_run);
        end
        beat(32'hDDDD_0004, 32'h20, "beat_d");
        step();
        fetch_addr = 32'h20;
        #1;
        vecs++;
        if (cpu_run !== 1'b1 || fetch_instr !== 32'hDDDD_0004) begin
            fails++;
            $display("FAIL reload_run: run=%b instr=%h, want 1 dddd0004", cpu_run, fetch_instr);
        end
        @(negedge clk);
        halt = 1'b1;
        #1;
        vecs++;
        if (cpu_run !== 1'b1) begin
            fails++;
            $display("FAIL halt_same_cycle: run=%b, want 1", cpu_run);
        end
        @(negedge clk);
        halt = 1'b0;
        #1;
        vecs++;
        if (cpu_run !== 1'b0 || busy !== 1'b0 || fetch_instr !== 32'h0) begin
            fails++;
            $display("FAIL halt_idle: run=%b busy=%b instr=%h, want 0 0 00000000",
                     cpu_run, busy, fetch_instr);
        end
        ld_valid = 1'b1;
        ld_data  = 32'h5555_5555;
        step();
        ld_valid = 1'b0;
        vecs++;
        if (wa.size() - n0 != 1) begin
            fails++;
            $display("FAIL idle_ignore: writes=%0d, want 1", wa.size() - n0);
        end
    endtask

    task automatic test_wrap();
        int n0;
        n0 = wa.size();
        start(32'hABCD_FFFF, 17'd2);
        beat(32'hEEEE_0005, 32'h0000_FFFF, "wrap_e");
        beat(32'hFFFF_0006, 32'h0000_0000, "wrap_f");
        vecs++;
        if (wa.size() - n0 != 2 || pc_reset !== 1'b1) begin
            fails++;
            $display("FAIL wrap_count: writes=%0d pcr=%b, want 2 1", wa.size() - n0, pc_reset);
        end
        step();
        vecs++;
        if (tmem[16'hFFFF] !== 32'hEEEE_0005 || tmem[16'h0000] !== 32'hFFFF_0006
            || cpu_run !== 1'b1) begin
            fails++;
            $display("FAIL wrap_mem: mffff=%h m0=%h run=%b, want eeee0005 ffff0006 1",
                     tmem[16'hFFFF], tmem[16'h0000], cpu_run);
        end
    endtask

    task automatic test_len0();
        int n0;
        n0 = wa.size();
        start(32'h30, 17'd0);
        vecs++;
        if (pc_reset !== 1'b1 || load_done !== 1'b1 || ld_ready !== 1'b0) begin
            fails++;
            $display("FAIL len0_flush: pcr=%b done=%b rdy=%b, want 1 1 0",
                     pc_reset, load_done, ld_ready);
        end
        step();
        vecs++;
        if (cpu_run !== 1'b1 || wa.size() != n0) begin
            fails++;
            $display("FAIL len0_run: run=%b writes=%0d, want 1 0", cpu_run, wa.size() - n0);
        end
    endtask

    task automatic test_ovf();
        start(32'h40, 17'd3);
        vecs++;
        if (err_ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear0: ovf=%b, want 0", err_ovf);
        end
        beat(32'h1111_0007, 32'h40, "ovf_g");
        start(32'h80, 17'd5);
        vecs++;
        if (err_ovf !== 1'b1 || ld_ready !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set: ovf=%b rdy=%b, want 1 1", err_ovf, ld_ready);
        end
        beat(32'h2222_0008, 32'h41, "ovf_h");
        beat(32'h3333_0009, 32'h42, "ovf_i");
        vecs++;
        if (pc_reset !== 1'b1 || err_ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_flush: pcr=%b ovf=%b, want 1 1", pc_reset, err_ovf);
        end
        step();
        start(32'h50, 17'd4);
        vecs++;
        if (err_ovf !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL ovf_reclear: ovf=%b busy=%b, want 0 1", err_ovf, busy);
        end
    endtask

    task automatic test_reset_mid();
        beat(32'h4444_000A, 32'h50, "mid_beat");
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = 32'h7777_7777;
        fetch_addr = 32'h50;
        rst = 1'b0;
        #1;
        vecs++;
        if (ld_ready !== 1'b0 || mem_write_en !== 1'b0 || cpu_run !== 1'b0
            || fetch_instr !== 32'h0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: rdy=%b we=%b run=%b instr=%h busy=%b, want 0 0 0 0 0",
                     ld_ready, mem_write_en, cpu_run, fetch_instr, busy);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        rst = 1'b1;
        step();
    endtask

    initial begin
        load_start = 1'b0;
        load_base  = '0;
        load_len   = '0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        halt       = 1'b0;
        fetch_addr = '0;
        test_reset();
        test_load_basic();
        test_halt();
        test_wrap();
        test_len0();
        test_ovf();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
